// File: rtl/parallax_field_gen.sv
// parallax_field_gen
//   Parallax background for the 256x256 playfield: NUM_STARS scrolling LFSR
//   star layers (deeper layers step less often) and NUM_RIDGES random-walk
//   mountain ridges, composited by priority into a registered 3-bit colour.
//
// Ports
//   clk         pixel clock
//   reset       asynchronous reset, active low
//   hpos, vpos  pixel / line position from the sync generator
//   display_on  visible-area flag
//   pause       freezes scrolling and the frame counter
//   seed_load   single-cycle reseed strobe (wins over frame start and pause)
//   seed        reseed value, 0 is replaced by 16'hACE1
//   rgb         registered pixel colour, one cycle after hpos/vpos
//   frame       frame counter
module parallax_field_gen #(
    parameter int                          NUM_STARS     = 3,
    parameter int                          NUM_RIDGES    = 2,
    parameter int                          DENSITY       = 9,
    parameter logic [15:0]                 SEED          = 16'hACE1,
    parameter logic [9*NUM_RIDGES-1:0]     RIDGE_INIT    = {9'd180, 9'd200},
    parameter logic [4*NUM_RIDGES-1:0]     RIDGE_SPEED   = {4'd3, 4'd6},
    parameter int                          RIDGE_MIN     = 64,
    parameter int                          RIDGE_MAX     = 250,
    parameter logic [3*NUM_RIDGES-1:0]     RIDGE_PALETTE = {3'b001, 3'b010}
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [8:0]  hpos,
    input  logic [8:0]  vpos,
    input  logic        display_on,
    input  logic        pause,
    input  logic        seed_load,
    input  logic [15:0] seed,
    output logic [2:0]  rgb,
    output logic [7:0]  frame
);

    localparam logic [15:0] SEED_EFF  = (SEED == 16'd0) ? 16'hACE1 : SEED;
    // Top DENSITY bits of the star LFSR must all be set for a star.
    localparam logic [15:0] STAR_MASK = ~(16'hFFFF >> DENSITY);

    logic        win;
    logic        fs;
    logic [15:0] seed_eff;

    assign win      = !hpos[8] && !vpos[8];
    assign fs       = (hpos == 9'd0) && (vpos == 9'd0);
    assign seed_eff = (seed == 16'd0) ? 16'hACE1 : seed;

    function automatic logic [15:0] rotl16(input logic [15:0] v, input int k);
        rotl16 = (v << k) | (v >> (16 - k));
    endfunction

    function automatic logic [15:0] star_next(input logic [15:0] l);
        star_next = {1'b0, l[15:1]} ^ (l[0] ? 16'hB400 : 16'h0000);
    endfunction

    function automatic logic [7:0] ridge_next(input logic [7:0] l);
        ridge_next = {1'b0, l[7:1]} ^ (l[0] ? 8'hB8 : 8'h00);
    endfunction

    // One random-walk step; a move outside [RIDGE_MIN, RIDGE_MAX] holds.
    // 10-bit arithmetic so that 0-1 wraps high and is rejected by the clamp.
    function automatic logic [8:0] walk(input logic [8:0] h, input logic up);
        logic [9:0] n;
        n = up ? ({1'b0, h} + 10'd1) : ({1'b0, h} - 10'd1);
        if (n < 10'(RIDGE_MIN) || n > 10'(RIDGE_MAX))
            walk = h;
        else
            walk = n[8:0];
    endfunction

    logic [NUM_STARS-1:0]    star_hit;
    logic [3*NUM_STARS-1:0]  star_col;
    logic [NUM_RIDGES-1:0]   ridge_hit;

    for (genvar k = 0; k < NUM_STARS; k++) begin : g_star
        localparam logic [8:0] STEP_MASK = 9'((1 << k) - 1);
        logic [15:0] lfsr;
        logic [15:0] snap;
        logic        step;

        assign step              = win && ((hpos & STEP_MASK) == 9'd0);
        assign star_hit[k]       = step && ((lfsr & STAR_MASK) == STAR_MASK);
        assign star_col[3*k +: 3] = lfsr[2:0] | 3'b001;

        // Pause replays the frame from the snapshot taken at the last
        // unpaused frame start, so a paused picture stays still.
        always_ff @(posedge clk or negedge reset) begin
            if (!reset) begin
                lfsr <= rotl16(SEED_EFF, k);
                snap <= rotl16(SEED_EFF, k);
            end else if (seed_load) begin
                lfsr <= rotl16(seed_eff, k);
                snap <= rotl16(seed_eff, k);
            end else if (fs && pause) begin
                lfsr <= snap;
            end else begin
                if (fs)
                    snap <= lfsr;
                if (step)
                    lfsr <= star_next(lfsr);
            end
        end
    end

    for (genvar r = 0; r < NUM_RIDGES; r++) begin : g_ridge
        localparam logic [8:0] INIT_H = RIDGE_INIT[9*r +: 9];
        localparam logic [7:0] INIT_L = 8'(8'h60 + r);
        localparam logic [8:0] SPD    = {5'd0, RIDGE_SPEED[4*r +: 4]};
        logic [8:0] height;
        logic [8:0] snap_h;
        logic [7:0] lfsr;
        logic [7:0] snap_l;
        logic       frame_step;

        // Snapshot advances RIDGE_SPEED steps on line 256 (outside the window),
        // which is what scrolls the ridge between frames.
        assign frame_step   = (vpos == 9'd256) && (hpos < SPD) && !pause;
        assign ridge_hit[r] = win && (height < vpos);

        always_ff @(posedge clk or negedge reset) begin
            if (!reset) begin
                height <= INIT_H;
                snap_h <= INIT_H;
                lfsr   <= INIT_L;
                snap_l <= INIT_L;
            end else if (seed_load) begin
                height <= INIT_H;
                snap_h <= INIT_H;
                lfsr   <= INIT_L;
                snap_l <= INIT_L;
            end else begin
                if (frame_step) begin
                    snap_l <= ridge_next(snap_l);
                    snap_h <= walk(snap_h, snap_l[0]);
                end
                if (hpos[8]) begin
                    height <= snap_h;
                    lfsr   <= snap_l;
                end else if (win) begin
                    lfsr   <= ridge_next(lfsr);
                    height <= walk(height, lfsr[0]);
                end
            end
        end
    end

    logic [2:0] pix;

    // Descending loops so the lowest index is written last and wins;
    // ridges are applied after stars so any ridge covers any star.
    always_comb begin
        pix = 3'd0;
        for (int k = NUM_STARS - 1; k >= 0; k--)
            if (star_hit[k])
                pix = star_col[3*k +: 3];
        for (int r = NUM_RIDGES - 1; r >= 0; r--)
            if (ridge_hit[r])
                pix = RIDGE_PALETTE[3*r +: 3];
        if (!display_on || !win)
            pix = 3'd0;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rgb   <= 3'd0;
            frame <= 8'd0;
        end else begin
            rgb <= pix;
            if (!seed_load && fs && !pause)
                frame <= frame + 8'd1;
        end
    end

endmodule

// File: tb/tb_parallax_field_gen.sv
// Bench for parallax_field_gen: default-parameter DUT checked every cycle
// against a behavioural model through a scoreboard queue, plus a clamped
// instance (RIDGE_MIN == RIDGE_MAX == 150) checked on column 0.
module tb_parallax_field_gen;

    logic        clk = 1'b0;
    logic        reset;
    logic [8:0]  hpos, vpos;
    logic        display_on, pause, seed_load;
    logic [15:0] seed;
    logic [2:0]  rgb, rgb_c;
    logic [7:0]  frame, frame_c;

    always #5 clk = ~clk;

    parallax_field_gen dut (
        .clk(clk), .reset(reset), .hpos(hpos), .vpos(vpos),
        .display_on(display_on), .pause(pause), .seed_load(seed_load),
        .seed(seed), .rgb(rgb), .frame(frame)
    );

    parallax_field_gen #(
        .RIDGE_MIN(150), .RIDGE_MAX(150), .RIDGE_INIT({9'd150, 9'd150})
    ) dut_clamp (
        .clk(clk), .reset(reset), .hpos(hpos), .vpos(vpos),
        .display_on(display_on), .pause(pause), .seed_load(seed_load),
        .seed(seed), .rgb(rgb_c), .frame(frame_c)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [15:0] got, input logic [15:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    task automatic check_ne(input string name, input logic [15:0] got, input logic [15:0] bad);
        n_checks++;
        if (got === bad) begin
            n_fail++;
            $display("FAIL %s: got %0h which must not be %0h", name, got, bad);
        end
    endtask

    // ---------------- behavioural model (default parameters) ----------------
    localparam int M_MIN = 64;
    localparam int M_MAX = 250;
    int         m_init [2] = '{200, 180};
    int         m_spd  [2] = '{6, 3};
    logic [2:0] m_pal  [2] = '{3'b010, 3'b001};

    logic [15:0] m_sl [3];
    logic [15:0] m_ss [3];
    logic [7:0]  m_rl [2];
    logic [7:0]  m_rsl[2];
    logic [8:0]  m_rh [2];
    logic [8:0]  m_rsh[2];
    logic [7:0]  m_frame;

    function automatic logic [15:0] m_rot(input logic [15:0] v, input int k);
        logic [15:0] t;
        t = v;
        for (int i = 0; i < k; i++) t = {t[14:0], t[15]};
        return t;
    endfunction

    function automatic logic [15:0] m_gal16(input logic [15:0] v);
        if (v[0]) return (v >> 1) ^ 16'hB400;
        return v >> 1;
    endfunction

    function automatic logic [7:0] m_gal8(input logic [7:0] v);
        if (v[0]) return (v >> 1) ^ 8'hB8;
        return v >> 1;
    endfunction

    function automatic logic [8:0] m_walk(input logic [8:0] h, input logic up);
        int nh;
        nh = up ? int'(h) + 1 : int'(h) - 1;
        if (nh < M_MIN || nh > M_MAX) return h;
        return 9'(nh);
    endfunction

    task automatic model_load(input logic [15:0] s);
        for (int k = 0; k < 3; k++) begin
            m_sl[k] = m_rot(s, k);
            m_ss[k] = m_rot(s, k);
        end
        for (int r = 0; r < 2; r++) begin
            m_rh[r]  = 9'(m_init[r]);
            m_rsh[r] = 9'(m_init[r]);
            m_rl[r]  = 8'(8'h60 + r);
            m_rsl[r] = 8'(8'h60 + r);
        end
    endtask

    task automatic model_reset();
        model_load(16'hACE1);
        m_frame = 8'd0;
    endtask

    task automatic model_step(input logic [8:0] h, input logic [8:0] v, input logic d,
                              input logic p, input logic sl, input logic [15:0] sd,
                              output logic [2:0] e);
        logic win, fs, found, stepc;
        win   = !h[8] && !v[8];
        fs    = (h == 9'd0) && (v == 9'd0);
        e     = 3'd0;
        found = 1'b0;
        if (d && win) begin
            for (int r = 0; r < 2; r++)
                if (!found && m_rh[r] < v) begin
                    e = m_pal[r];
                    found = 1'b1;
                end
            for (int k = 0; k < 3; k++)
                if (!found && (int'(h) % (1 << k)) == 0 && m_sl[k][15:7] == 9'h1FF) begin
                    e = m_sl[k][2:0] | 3'b001;
                    found = 1'b1;
                end
        end
        if (sl) begin
            model_load((sd == 16'd0) ? 16'hACE1 : sd);
        end else begin
            for (int k = 0; k < 3; k++) begin
                stepc = win && ((int'(h) % (1 << k)) == 0);
                if (fs && p) m_sl[k] = m_ss[k];
                else begin
                    if (fs) m_ss[k] = m_sl[k];
                    if (stepc) m_sl[k] = m_gal16(m_sl[k]);
                end
            end
            for (int r = 0; r < 2; r++) begin
                if (v == 9'd256 && int'(h) < m_spd[r] && !p) begin
                    m_rsh[r] = m_walk(m_rsh[r], m_rsl[r][0]);
                    m_rsl[r] = m_gal8(m_rsl[r]);
                end
                if (h[8]) begin
                    m_rh[r] = m_rsh[r];
                    m_rl[r] = m_rsl[r];
                end else if (win) begin
                    m_rh[r] = m_walk(m_rh[r], m_rl[r][0]);
                    m_rl[r] = m_gal8(m_rl[r]);
                end
            end
            if (fs && !p) m_frame = m_frame + 8'd1;
        end
    endtask

    // ---------------- stimulus and scoreboard ----------------
    logic [2:0] exp_q[$];
    logic [2:0] cap_got[256];
    logic [2:0] cap_exp[256];
    logic [2:0] ref0[256];
    logic [2:0] pexp[256];

    task automatic drive(input logic [8:0] h, input logic [8:0] v, input logic d,
                         input logic p, input logic sl, input logic [15:0] sd,
                         output logic [2:0] got, output logic [2:0] e);
        logic [2:0] want;
        hpos = h; vpos = v; display_on = d; pause = p; seed_load = sl; seed = sd;
        model_step(h, v, d, p, sl, sd, e);
        exp_q.push_back(e);
        @(posedge clk);
        #1;
        got  = rgb;
        want = exp_q.pop_front();
        check("rgb_sb", 16'(rgb), 16'(want));
        check("frame_sb", 16'(frame), 16'(m_frame));
        seed_load = 1'b0;
    endtask

    // Compressed frame: column 0 plus one blanking pixel per line, then the
    // first pixels of line 256 where the ridge snapshots advance.
    task automatic run_frame(input logic p);
        logic [2:0] g, e;
        int bad;
        bad = 0;
        for (int v = 0; v < 256; v++) begin
            drive(9'd0, 9'(v), 1'b1, p, 1'b0, 16'd0, g, e);
            cap_got[v] = g;
            cap_exp[v] = e;
            if ((v >= 151) != (rgb_c === 3'b010)) bad++;
            drive(9'd256, 9'(v), 1'b1, p, 1'b0, 16'd0, g, e);
        end
        for (int h = 0; h < 8; h++)
            drive(9'(h), 9'd256, 1'b1, p, 1'b0, 16'd0, g, e);
        check("clamp_col0_bad_lines", 16'(bad), 16'd0);
    endtask

    typedef struct {
        logic [8:0] h;
        logic [8:0] v;
        logic       d;
        logic [2:0] e;
        logic       neq;
        string      name;
    } vec_t;

    vec_t tbl[10];

    initial begin
        logic [2:0] g, e;
        int bad;

        reset = 1'b0; hpos = 9'd0; vpos = 9'd0; display_on = 1'b0;
        pause = 1'b0; seed_load = 1'b0; seed = 16'd0;
        repeat (5) @(posedge clk);
        #1;
        check("reset_rgb", 16'(rgb), 16'd0);
        check("reset_frame", 16'(frame), 16'd0);
        model_reset();
        reset = 1'b1;

        // First frame after reset; kept as the reference stream.
        run_frame(1'b0);
        ref0 = cap_exp;
        check("first_fs_frame", 16'(frame), 16'd1);
        check("ridge_v255", 16'(cap_got[255]), 16'(3'b010));
        check_ne("no_ridge_v100", 16'(cap_got[100]), 16'(3'b010));

        tbl[0] = '{9'd300, 9'd254, 1'b1, 3'd0,   1'b0, "reload_offwin"};
        tbl[1] = '{9'd0,   9'd255, 1'b1, 3'b010, 1'b0, "ridge0_v255"};
        tbl[2] = '{9'd300, 9'd100, 1'b1, 3'd0,   1'b0, "offwin_h300"};
        tbl[3] = '{9'd256, 9'd189, 1'b1, 3'd0,   1'b0, "blank_h256"};
        tbl[4] = '{9'd0,   9'd190, 1'b1, 3'b001, 1'b0, "ridge1_v190"};
        tbl[5] = '{9'd0,   9'd100, 1'b1, 3'b010, 1'b1, "no_ridge_v100"};
        tbl[6] = '{9'd50,  9'd50,  1'b0, 3'd0,   1'b0, "display_off"};
        tbl[7] = '{9'd100, 9'd300, 1'b1, 3'd0,   1'b0, "offwin_v300"};
        tbl[8] = '{9'd511, 9'd511, 1'b1, 3'd0,   1'b0, "corner_511"};
        tbl[9] = '{9'd256, 9'd100, 1'b0, 3'd0,   1'b0, "blank_display_off"};
        for (int i = 0; i < 10; i++) begin
            drive(tbl[i].h, tbl[i].v, tbl[i].d, 1'b0, 1'b0, 16'd0, g, e);
            if (tbl[i].neq) check_ne(tbl[i].name, 16'(g), 16'(tbl[i].e));
            else            check(tbl[i].name, 16'(g), 16'(tbl[i].e));
        end

        // Clamped instance is checked inside every frame; run four here.
        repeat (4) run_frame(1'b0);
        check("frame_after_5", 16'(frame), 16'd5);

        // Pause for three frames: frames 2 and 3 must be identical.
        run_frame(1'b1);
        run_frame(1'b1);
        pexp = cap_exp;
        run_frame(1'b1);
        bad = 0;
        for (int v = 0; v < 256; v++) if (cap_got[v] !== pexp[v]) bad++;
        check("pause_frame3_vs_frame2", 16'(bad), 16'd0);
        check("pause_frame_held", 16'(frame), 16'd5);
        run_frame(1'b0);
        check("unpause_frame", 16'(frame), 16'd6);

        // Reseed with 0 reproduces the post-reset stream.
        drive(9'd300, 9'd300, 1'b1, 1'b0, 1'b1, 16'd0, g, e);
        check("seed_load_frame_kept", 16'(frame), 16'd6);
        run_frame(1'b0);
        bad = 0;
        for (int v = 0; v < 256; v++) if (cap_got[v] !== ref0[v]) bad++;
        check("reseed0_vs_reset_stream", 16'(bad), 16'd0);

        drive(9'd300, 9'd300, 1'b1, 1'b0, 1'b1, 16'h1234, g, e);
        run_frame(1'b0);
        check("frame_after_reseed", 16'(frame), 16'd8);

        // seed_load coincident with frame start: no frame increment.
        drive(9'd0, 9'd0, 1'b1, 1'b0, 1'b1, 16'hBEEF, g, e);
        check("seed_load_beats_fs", 16'(frame), 16'd8);
        run_frame(1'b0);
        check("frame_after_beef", 16'(frame), 16'd9);

        // Reset mid-frame, then a clean restart at the next frame start.
        for (int v = 0; v < 100; v++) begin
            drive(9'd0, 9'(v), 1'b1, 1'b0, 1'b0, 16'd0, g, e);
            drive(9'd256, 9'(v), 1'b1, 1'b0, 1'b0, 16'd0, g, e);
        end
        reset = 1'b0;
        #1;
        check("midreset_rgb", 16'(rgb), 16'd0);
        check("midreset_frame", 16'(frame), 16'd0);
        @(posedge clk);
        @(posedge clk);
        #1;
        model_reset();
        reset = 1'b1;
        run_frame(1'b0);
        bad = 0;
        for (int v = 0; v < 256; v++) if (cap_got[v] !== ref0[v]) bad++;
        check("restart_vs_reset_stream", 16'(bad), 16'd0);
        check("restart_frame", 16'(frame), 16'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/parallax_field_gen.md
Name: parallax_field_gen

Overview:
- Parametrised parallax background generator for the 256x256 playfield.
- Produces N scrolling LFSR star layers, where deeper layers step more slowly, and M random-walk mountain ridges with per-ridge scroll speed and height clamping.
- Provides pause and runtime reseed, and composites by priority rather than by summing.
- Sits between the external sync generator (hpos/vpos/display_on) and the RGB output mux.

Parameters:
- NUM_STARS, 3: star layers, 1..4.
- NUM_RIDGES, 2: ridge layers, 1..4.
- DENSITY, 9: number of top star-LFSR bits that must all be 1 for a star (1..16).
- SEED, 16'hACE1: star seed. A value of 0 is replaced by 16'hACE1.
- RIDGE_INIT, {9'd180,9'd200}: packed 9-bit initial height per ridge, ridge 0 in the LSBs.
- RIDGE_SPEED, {4'd3,4'd6}: packed 4-bit walk steps per frame per ridge.
- RIDGE_MIN, 64: lower height clamp.
- RIDGE_MAX, 250: upper height clamp.
- RIDGE_PALETTE, {3'b001,3'b010}: packed 3-bit colour per ridge.

Ports:
- clk  in  1  pixel clock.
- reset  in  1  asynchronous, active-low reset (0 = reset).
- hpos  in  9  horizontal pixel position from the sync generator.
- vpos  in  9  vertical line position from the sync generator.
- display_on  in  1  visible-area flag.
- pause  in  1  freezes scroll and the frame counter.
- seed_load  in  1  single-cycle reseed strobe.
- seed  in  16  reseed value; 0 is replaced by 16'hACE1.
- rgb  out  3  registered pixel colour.
- frame  out  8  frame counter.

Behaviour:
- Window: win = !hpos[8] & !vpos[8]. Frame start: fs = (hpos==0 && vpos==0).
- Reset (reset==0, async):
  - rgb=0, frame=0.
  - Star k lfsr and snapshot = SEED rotated left by k.
  - Ridge r: LFSR and snapshot LFSR = 8'h60+r; working and snapshot height = RIDGE_INIT[r].
- Star layer k:
  - 16-bit right-shift Galois LFSR: next = (l>>1) ^ (l[0] ? 16'hB400 : 0). Period 65535, so the pattern shifts one pixel per frame.
  - Steps when win && hpos[k-1:0]==0 (every pixel for k=0).
  - Hit when win, step condition true, and l[15:16-DENSITY] all 1. Colour = l[2:0] | 3'b001, never black.
- Star pause: at fs, if pause, l <= snapshot (restores frame-start state); else snapshot <= l.
- Ridge r, per frame:
  - When vpos==256 && hpos<RIDGE_SPEED[r] && !pause: snapshot LFSR steps (8-bit Galois, taps 8'hB8).
  - Snapshot height moves +1 if the old LFSR bit0 is 1, else -1.
  - A move that would leave [RIDGE_MIN,RIDGE_MAX] holds the height; the LFSR still steps.
- Ridge r, per line:
  - While hpos[8]==1, working LFSR and height reload from the snapshot.
  - While win, they step with the same rule and clamps.
  - Hit when win && height < vpos.
- Composition, registered with 1-cycle latency (rgb at cycle t+1 reflects hpos/vpos at cycle t):
  - !display_on or !win -> 0.
  - Else the lowest-index ridge hit -> RIDGE_PALETTE[r].
  - Else the lowest-index star hit -> its colour.
  - Else 0.
- frame increments (mod 256) at fs when !pause.
- seed_load (synchronous), priority over fs and pause:
  - Star lfsr and snapshot <= seed rotated left by k.
  - Ridge heights (working and snapshot) <= RIDGE_INIT; ridge LFSRs <= 8'h60+r.
  - frame is unchanged.
- Simultaneous cases:
  - seed_load beats fs and pause.
  - A ridge clamp and a step on the same cycle: the clamp wins.
  - pause asserted mid-frame takes effect at the next fs (stars) or the next vpos==256 line (ridges).
- Reset asserted mid-frame: immediate return to reset values. The generator restarts cleanly at the next fs, with no phase dependence on hpos/vpos at release.

Test Plan:
- Reset:
  - Hold reset=0 for 5 clocks, then release -> rgb==0 and frame==0.
  - The first fs after release -> frame==1.
- Off-window and blanking:
  - hpos=300, vpos=100, display_on=1 -> rgb==0.
  - display_on=0 anywhere -> rgb==0 one cycle later.
- Ridge rendering at defaults, first frame:
  - hpos=0, vpos=255 -> rgb==3'b010 (height 200 < 255).
  - hpos=0, vpos=100 -> rgb is a star colour or 0, never 3'b010.
- Clamp:
  - Set RIDGE_MIN=RIDGE_MAX=150 and run 4 frames.
  - Column 0: rgb==ridge colour exactly for vpos 151..255 in every frame.
- Pause:
  - pause=1 for 3 frames -> identical rgb streams for frames 2 and 3, and frame held constant.
  - Release pause -> stars shift one pixel per frame again.
- Reseed:
  - seed_load with seed=0 -> the rgb stream equals the post-reset stream with SEED=16'hACE1.
  - seed_load with seed=16'h1234 -> matches the reference model, star-for-star, over one frame.
